tcp_session_ctrl: RTL
=====================

// Module: tcp_session_ctrl
// PURPOSE
//  Single-connection TCP session sequencer for the order-entry port. Takes per-segment header fields
//  from the TCP decode stage, runs the passive-open/close FSM and tracks snd_nxt/rcv_nxt.
//  Issues reply-header requests (SYN|ACK, ACK, FIN|ACK, RST) to the TX segment builder over valid/ready.
//  Qualifies in-order payload for the downstream FIX parser.
// PARAMETERS
//  LOCAL_PORT      16'd9000       TCP destination port accepted
//  ISS             32'h0000_1000  initial send sequence number
//  TIMEOUT_CYCLES  1000000        idle limit in SYN_RCVD / LAST_ACK before return to LISTEN
//  CNT_W           16             width of drop counter (saturating)
// PORTS
//  clk             in   1    system clock
//  rst_n           in   1    asynchronous active-low reset
//  cfg_listen      in   1    1 = open port; 0 = force CLOSED
//  rx_valid        in   1    1-cycle strobe: segment header fields valid
//  rx_flags        in   6    {URG,ACK,PSH,RST,SYN,FIN}
//  rx_src_port     in   16   peer port
//  rx_dst_port     in   16   local port in segment
//  rx_seq          in   32   segment sequence number
//  rx_ack          in   32   segment acknowledgement number
//  rx_payload_len  in   16   payload bytes in segment
//  tx_req_valid    out  1    reply request pending
//  tx_req_ready    in   1    builder accepts request
//  tx_flags        out  6    reply flags
//  tx_seq          out  32   reply sequence number
//  tx_ack          out  32   reply acknowledgement number
//  tx_dst_port     out  16   peer port for reply
//  payload_accept  out  1    1-cycle pulse: current segment payload is in-order, forward it
//  sess_state      out  3    FSM state
//  drop_cnt        out  CNT_W  dropped/rejected segments, saturates at all-ones
// BEHAVIOUR
//  Reset (async): state CLOSED; all outputs 0; snd_nxt=ISS, rcv_nxt=0, peer port 0, timer 0.
//  Latency: rx_valid at cycle N -> state update, payload_accept, and tx_req_valid all at N+1.
//  Handshake: tx_req_valid and tx_* stay stable until tx_req_ready is high. Single-entry slot.
//    rx_valid while the slot is busy and not being accepted that cycle -> segment dropped, drop_cnt+1.
//    rx_valid in the same cycle the slot is accepted -> processed normally.
//  Port filter: rx_dst_port!=LOCAL_PORT, or (state!=LISTEN and rx_src_port!=peer) -> drop, drop_cnt+1.
//  FSM (states CLOSED=0, LISTEN=1, SYN_RCVD=2, ESTAB=3, LAST_ACK=4):
//   CLOSED:   cfg_listen=1 -> LISTEN. All segments ignored, no count.
//   LISTEN:   SYN without ACK or RST -> latch peer, rcv_nxt=rx_seq+1;
//             reply SYN|ACK seq=ISS ack=rcv_nxt; snd_nxt=ISS+1; -> SYN_RCVD. Other segments -> drop.
//   SYN_RCVD: ACK and rx_ack==snd_nxt -> ESTAB; RST -> LISTEN; bad ack -> reply RST seq=rx_ack, stay.
//   ESTAB:    rx_seq==rcv_nxt and len!=0 -> payload_accept, rcv_nxt+=len, reply ACK.
//             rx_seq!=rcv_nxt -> duplicate ACK with unchanged rcv_nxt, no accept, drop_cnt+1.
//             FIN (in order) -> rcv_nxt+=len+1; reply FIN|ACK seq=snd_nxt; snd_nxt+=1; -> LAST_ACK.
//               Payload carried with FIN is accepted.
//             RST -> LISTEN, no reply. SYN -> reply RST seq=snd_nxt, -> LISTEN.
//             Pure ACK with len=0 -> no reply.
//   LAST_ACK: ACK and rx_ack==snd_nxt -> LISTEN; RST -> LISTEN.
//  Timer: clears on entry to SYN_RCVD/LAST_ACK, counts each cycle in them.
//    At TIMEOUT_CYCLES-1 -> LISTEN. If rx_valid arrives in that same cycle, the segment takes priority.
//  cfg_listen=0: -> CLOSED once the slot is empty (pending request still completes). No RST sent.
//  LISTEN re-entry resets snd_nxt=ISS, rcv_nxt=0, and peer port.
//  Arithmetic: all seq/ack math is modulo 2^32 (wrap is legal). len is zero-extended to 32 bits.
// STRUCTURE
//  tcp_pkg: flag constants FIN..URG, state encodings, LOCAL_PORT default.
//  Sub-module tcp_session_timer: load/count/expire for the timeout.
//  The FSM, seq tracking, and reply slot stay in this module.
// TESTING
//  1 Handshake: SYN seq=0x100 port 9000 -> SYN|ACK seq=0x1000 ack=0x101; ACK ack=0x1001 -> sess_state=3.
//  2 Data: ESTAB, seq=0x101 len=262 -> payload_accept pulse, ACK ack=0x207.
//    Resend seq=0x101 -> dup ACK ack=0x207, no accept, drop_cnt=1.
//  3 Wrap: SYN seq=0xFFFFFFF0, then data len=0x20 seq=0xFFFFFFF1 -> ACK ack=0x00000011.
//  4 Backpressure: tx_req_ready held 0 for 5 cycles, two data segments -> first request stable,
//    second dropped, drop_cnt+1.
//  5 Close: FIN seq=rcv_nxt -> FIN|ACK; ACK ack=snd_nxt -> LISTEN.
//    Separately, RST in ESTAB -> LISTEN, no request.
//  6 Timeout/reset: TIMEOUT_CYCLES=16, SYN then silence -> LISTEN at cycle 16.
//    rst_n low mid-ESTAB -> CLOSED, all outputs 0 immediately.

Source files
------------

// File: rtl/tcp_pkg.sv
// Shared definitions for the TCP session sequencer: flag masks, state encodings,
// reply-request record and default port/sequence constants.
package tcp_pkg;

    localparam logic [5:0] TCP_FIN = 6'b00_0001;
    localparam logic [5:0] TCP_SYN = 6'b00_0010;
    localparam logic [5:0] TCP_RST = 6'b00_0100;
    localparam logic [5:0] TCP_PSH = 6'b00_1000;
    localparam logic [5:0] TCP_ACK = 6'b01_0000;
    localparam logic [5:0] TCP_URG = 6'b10_0000;

    localparam logic [15:0] LOCAL_PORT_DEFAULT = 16'd9000;
    localparam logic [31:0] ISS_DEFAULT        = 32'h0000_1000;

    typedef enum logic [2:0] {
        ST_CLOSED   = 3'd0,
        ST_LISTEN   = 3'd1,
        ST_SYN_RCVD = 3'd2,
        ST_ESTAB    = 3'd3,
        ST_LAST_ACK = 3'd4
    } sess_state_e;

    typedef struct packed {
        logic [5:0]  flags;
        logic [31:0] seq;
        logic [31:0] ack;
        logic [15:0] port;
    } tx_req_t;

    function automatic logic has_flag(input logic [5:0] flags, input logic [5:0] mask);
        return |(flags & mask);
    endfunction

endpackage

// File: rtl/tcp_session_timer.sv
// Idle timer for the half-open/half-closed states: clears on load, counts while run,
// and holds at LIMIT-1 so a late expiry is never lost to wrap-around.
module tcp_session_timer #(
    parameter int unsigned LIMIT = 32'd1000000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load,
    input  logic run,
    output logic expired
);

    localparam int W = $clog2(LIMIT) + 1;
    localparam logic [W-1:0] LAST = W'(LIMIT - 32'd1);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // Next count: load wins over counting; saturate at the expiry value.
    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = '0;
        end else if (run && (cnt_q != LAST)) begin
            cnt_d = cnt_q + W'(1);
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired = (cnt_q == LAST);

endmodule

// File: rtl/tcp_session_ctrl.sv
// Single-connection passive-open TCP sequencer: tracks snd_nxt/rcv_nxt, issues reply
// header requests through a one-entry valid/ready slot and flags in-order payload.
module tcp_session_ctrl
    import tcp_pkg::*;
#(
    parameter logic [15:0] LOCAL_PORT     = LOCAL_PORT_DEFAULT,
    parameter logic [31:0] ISS            = ISS_DEFAULT,
    parameter int unsigned TIMEOUT_CYCLES = 32'd1000000,
    parameter int unsigned CNT_W          = 32'd16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cfg_listen,
    input  logic             rx_valid,
    input  logic [5:0]       rx_flags,
    input  logic [15:0]      rx_src_port,
    input  logic [15:0]      rx_dst_port,
    input  logic [31:0]      rx_seq,
    input  logic [31:0]      rx_ack,
    input  logic [15:0]      rx_payload_len,
    output logic             tx_req_valid,
    input  logic             tx_req_ready,
    output logic [5:0]       tx_flags,
    output logic [31:0]      tx_seq,
    output logic [31:0]      tx_ack,
    output logic [15:0]      tx_dst_port,
    output logic             payload_accept,
    output logic [2:0]       sess_state,
    output logic [CNT_W-1:0] drop_cnt
);

    sess_state_e      state_q, state_d;
    logic [31:0]      snd_nxt_q, snd_nxt_d;
    logic [31:0]      rcv_nxt_q, rcv_nxt_d;
    logic [15:0]      peer_q, peer_d;
    logic [CNT_W-1:0] drop_q, drop_d;
    logic             accept_q, accept_d;
    logic             req_valid_q, req_valid_d;
    tx_req_t          req_q, req_d;

    logic        slot_busy_s, port_ok_s, in_order_s, ack_ok_s;
    logic        reject_s, reply_en_s;
    tx_req_t     reply_s;
    logic [31:0] len_s;
    logic        timer_load_s, timer_run_s, timer_expired_s;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    assign timer_run_s  = (state_q == ST_SYN_RCVD) || (state_q == ST_LAST_ACK);
    assign timer_load_s = (state_d != state_q) &&
                          ((state_d == ST_SYN_RCVD) || (state_d == ST_LAST_ACK));

    tcp_session_timer #(.LIMIT(TIMEOUT_CYCLES)) u_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .load    (timer_load_s),
        .run     (timer_run_s),
        .expired (timer_expired_s)
    );

    // Segment processing, reply generation and next-state selection.
    always_comb begin
        state_d     = state_q;
        snd_nxt_d   = snd_nxt_q;
        rcv_nxt_d   = rcv_nxt_q;
        peer_d      = peer_q;
        drop_d      = drop_q;
        accept_d    = 1'b0;
        req_d       = req_q;
        slot_busy_s = req_valid_q && !tx_req_ready;
        req_valid_d = slot_busy_s;
        reject_s    = 1'b0;
        reply_en_s  = 1'b0;
        reply_s     = '0;
        len_s       = {16'h0000, rx_payload_len};
        in_order_s  = (rx_seq == rcv_nxt_q);
        ack_ok_s    = has_flag(rx_flags, TCP_ACK) && (rx_ack == snd_nxt_q);
        port_ok_s   = (rx_dst_port == LOCAL_PORT) &&
                      ((state_q == ST_LISTEN) || (rx_src_port == peer_q));

        case (state_q)
            ST_CLOSED: begin
                if (cfg_listen) begin
                    state_d = ST_LISTEN;
                end else begin
                    state_d = ST_CLOSED;
                end
            end
            default: begin
                if (!cfg_listen && !slot_busy_s) begin
                    state_d = ST_CLOSED;
                end else if (rx_valid) begin
                    if (slot_busy_s || !port_ok_s) begin
                        reject_s = 1'b1;
                    end else begin
                        case (state_q)
                            ST_LISTEN: begin
                                if (has_flag(rx_flags, TCP_SYN) &&
                                    !has_flag(rx_flags, TCP_ACK | TCP_RST)) begin
                                    peer_d     = rx_src_port;
                                    rcv_nxt_d  = rx_seq + 32'd1;
                                    snd_nxt_d  = ISS + 32'd1;
                                    reply_en_s = 1'b1;
                                    reply_s    = '{TCP_SYN | TCP_ACK, ISS, rx_seq + 32'd1, rx_src_port};
                                    state_d    = ST_SYN_RCVD;
                                end else begin
                                    reject_s = 1'b1;
                                end
                            end
                            ST_SYN_RCVD: begin
                                if (has_flag(rx_flags, TCP_RST)) begin
                                    state_d = ST_LISTEN;
                                end else if (ack_ok_s) begin
                                    state_d = ST_ESTAB;
                                end else if (has_flag(rx_flags, TCP_ACK)) begin
                                    reply_en_s = 1'b1;
                                    reply_s    = '{TCP_RST, rx_ack, rcv_nxt_q, peer_q};
                                end else begin
                                    reject_s = 1'b1;
                                end
                            end
                            ST_ESTAB: begin
                                if (has_flag(rx_flags, TCP_RST)) begin
                                    state_d = ST_LISTEN;
                                end else if (has_flag(rx_flags, TCP_SYN)) begin
                                    reply_en_s = 1'b1;
                                    reply_s    = '{TCP_RST, snd_nxt_q, rcv_nxt_q, peer_q};
                                    state_d    = ST_LISTEN;
                                end else if (!in_order_s) begin
                                    // Out-of-order: re-advertise rcv_nxt, payload discarded.
                                    reply_en_s = 1'b1;
                                    reply_s    = '{TCP_ACK, snd_nxt_q, rcv_nxt_q, peer_q};
                                    reject_s   = 1'b1;
                                end else if (has_flag(rx_flags, TCP_FIN)) begin
                                    accept_d   = (rx_payload_len != 16'd0);
                                    rcv_nxt_d  = rcv_nxt_q + len_s + 32'd1;
                                    snd_nxt_d  = snd_nxt_q + 32'd1;
                                    reply_en_s = 1'b1;
                                    reply_s    = '{TCP_FIN | TCP_ACK, snd_nxt_q,
                                                   rcv_nxt_q + len_s + 32'd1, peer_q};
                                    state_d    = ST_LAST_ACK;
                                end else if (rx_payload_len != 16'd0) begin
                                    accept_d   = 1'b1;
                                    rcv_nxt_d  = rcv_nxt_q + len_s;
                                    reply_en_s = 1'b1;
                                    reply_s    = '{TCP_ACK, snd_nxt_q, rcv_nxt_q + len_s, peer_q};
                                end else begin
                                    reply_en_s = 1'b0;
                                end
                            end
                            ST_LAST_ACK: begin
                                if (has_flag(rx_flags, TCP_RST) || ack_ok_s) begin
                                    state_d = ST_LISTEN;
                                end else begin
                                    reject_s = 1'b1;
                                end
                            end
                            default: begin
                                state_d = ST_CLOSED;
                            end
                        endcase
                    end
                end else if (timer_run_s && timer_expired_s) begin
                    state_d = ST_LISTEN;
                end else begin
                    state_d = state_q;
                end
            end
        endcase

        if (reject_s) begin
            drop_d = sat_inc(drop_q);
        end else begin
            drop_d = drop_q;
        end

        if (reply_en_s) begin
            req_valid_d = 1'b1;
            req_d       = reply_s;
        end else begin
            req_d = req_q;
        end

        // Any (re-)entry into LISTEN forgets the previous connection.
        if (state_d == ST_LISTEN) begin
            snd_nxt_d = ISS;
            rcv_nxt_d = 32'd0;
            peer_d    = 16'd0;
        end else begin
            peer_d = peer_d;
        end
    end

    // Session state, sequence tracking and reply slot registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_CLOSED;
            snd_nxt_q   <= ISS;
            rcv_nxt_q   <= 32'd0;
            peer_q      <= 16'd0;
            drop_q      <= '0;
            accept_q    <= 1'b0;
            req_valid_q <= 1'b0;
            req_q       <= '0;
        end else begin
            state_q     <= state_d;
            snd_nxt_q   <= snd_nxt_d;
            rcv_nxt_q   <= rcv_nxt_d;
            peer_q      <= peer_d;
            drop_q      <= drop_d;
            accept_q    <= accept_d;
            req_valid_q <= req_valid_d;
            req_q       <= req_d;
        end
    end

    assign tx_req_valid   = req_valid_q;
    assign tx_flags       = req_q.flags;
    assign tx_seq         = req_q.seq;
    assign tx_ack         = req_q.ack;
    assign tx_dst_port    = req_q.port;
    assign payload_accept = accept_q;
    assign sess_state     = state_q;
    assign drop_cnt       = drop_q;

endmodule
